// File: rtl/matrix_skew_feeder_if.sv
// matrix_skew_feeder_if
//   Operand-staging bus between the matrix-multiplier controller/memories and
//   the skew feeder.
//   master: controller side, drives read_en, rom_data, ram_data, start and
//           observes the feeder outputs.
//   slave : feeder side, drives a_out/a_valid (west edge), b_out/b_valid
//           (north edge), loaded, busy, done, overflow.
interface matrix_skew_feeder_if #(
    parameter int DATA_WIDTH = 32,
    parameter int DIM        = 4
);
    logic                      read_en;
    logic [DATA_WIDTH-1:0]     rom_data;
    logic [DATA_WIDTH-1:0]     ram_data;
    logic                      start;
    logic [DIM*DATA_WIDTH-1:0] a_out;
    logic [DIM-1:0]            a_valid;
    logic [DIM*DATA_WIDTH-1:0] b_out;
    logic [DIM-1:0]            b_valid;
    logic                      loaded;
    logic                      busy;
    logic                      done;
    logic                      overflow;

    modport master (
        output read_en, rom_data, ram_data, start,
        input  a_out, a_valid, b_out, b_valid, loaded, busy, done, overflow
    );

    modport slave (
        input  read_en, rom_data, ram_data, start,
        output a_out, a_valid, b_out, b_valid, loaded, busy, done, overflow
    );
endinterface

// File: rtl/matrix_skew_feeder.sv
// matrix_skew_feeder
//   Captures matrix A (ROM) and matrix B (RAM) into two DIM x DIM banks while
//   the controller reads, then streams them with diagonal skew into the west
//   (A rows) and north (B columns) edges of a systolic MAC array.
// Ports:
//   clk     : clock, rising edge
//   reset   : synchronous active-high reset
//   enable  : global advance; 0 freezes every register
//   bus     : matrix_skew_feeder_if.slave (read_en, rom_data, ram_data, start
//             in; a_out/a_valid, b_out/b_valid, loaded, busy, done, overflow out)
// Build option:
//   BANK_CLEAR_EN : when defined, both banks are zeroed on the DONE edge.
module matrix_skew_feeder #(
    parameter int DATA_WIDTH = 32,
    parameter int DIM        = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    matrix_skew_feeder_if.slave  bus
);
    localparam int N         = DIM * DIM;
    localparam int IW        = $clog2(N);
    localparam int CW        = IW + 1;
    localparam int SW        = $clog2(2 * DIM);
    localparam int LAST_STEP = 2 * DIM - 2;

    typedef enum logic [1:0] {LOAD, FULL, FEED, DONE} state_t;

    state_t                    state;
    logic [CW-1:0]             wr_cnt;
    logic                      rd_q;
    logic [SW-1:0]             step;

    logic [DATA_WIDTH-1:0]     bank_a [N];
    logic [DATA_WIDTH-1:0]     bank_b [N];

    logic [DIM*DATA_WIDTH-1:0] a_reg, b_reg, a_next, b_next;
    logic [DIM-1:0]            av_reg, bv_reg, av_next, bv_next;
    logic                      loaded_reg, busy_reg, done_reg, overflow_reg;
    logic [SW-1:0]             step_next;

    assign bus.a_out    = a_reg;
    assign bus.a_valid  = av_reg;
    assign bus.b_out    = b_reg;
    assign bus.b_valid  = bv_reg;
    assign bus.loaded   = loaded_reg;
    assign bus.busy     = busy_reg;
    assign bus.done     = done_reg;
    assign bus.overflow = overflow_reg;

    // Operand set for the step about to be registered: step 0 when leaving
    // FULL, otherwise the step after the one currently displayed.
    always_comb begin
        int k;
        k         = 0;
        step_next = (state == FEED) ? step + 1'b1 : '0;
        a_next    = '0;
        b_next    = '0;
        av_next   = '0;
        bv_next   = '0;
        for (int unsigned i = 0; i < DIM; i++) begin
            k = int'(step_next) - int'(i);
            if (k >= 0 && k < DIM) begin
                a_next[i*DATA_WIDTH +: DATA_WIDTH] = bank_a[IW'(int'(i) * DIM + k)];
                b_next[i*DATA_WIDTH +: DATA_WIDTH] = bank_b[IW'(k * DIM + int'(i))];
                av_next[i] = 1'b1;
                bv_next[i] = 1'b1;
            end
        end
    end

    // Banks carry no reset; contents are only meaningful once written.
    always_ff @(posedge clk) begin
        if (!reset && enable) begin
            if (state == LOAD && rd_q) begin
                bank_a[wr_cnt[IW-1:0]] <= bus.rom_data;
                bank_b[wr_cnt[IW-1:0]] <= bus.ram_data;
            end
`ifdef BANK_CLEAR_EN
            else if (state == DONE) begin
                for (int unsigned n = 0; n < N; n++) begin
                    bank_a[n] <= '0;
                    bank_b[n] <= '0;
                end
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= LOAD;
            wr_cnt       <= '0;
            rd_q         <= 1'b0;
            step         <= '0;
            a_reg        <= '0;
            b_reg        <= '0;
            av_reg       <= '0;
            bv_reg       <= '0;
            loaded_reg   <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            overflow_reg <= 1'b0;
        end else if (enable) begin
            rd_q <= bus.read_en;
            // Any capture outside LOAD is dropped but remembered.
            if (rd_q && state != LOAD) begin
                overflow_reg <= 1'b1;
            end
            case (state)
                LOAD: begin
                    if (rd_q) begin
                        if (wr_cnt == CW'(N - 1)) begin
                            wr_cnt     <= '0;
                            state      <= FULL;
                            loaded_reg <= 1'b1;
                        end else begin
                            wr_cnt <= wr_cnt + 1'b1;
                        end
                    end
                end
                FULL: begin
                    if (bus.start) begin
                        state      <= FEED;
                        step       <= step_next;
                        a_reg      <= a_next;
                        b_reg      <= b_next;
                        av_reg     <= av_next;
                        bv_reg     <= bv_next;
                        loaded_reg <= 1'b0;
                        busy_reg   <= 1'b1;
                    end
                end
                FEED: begin
                    if (step == SW'(LAST_STEP)) begin
                        state    <= DONE;
                        a_reg    <= '0;
                        b_reg    <= '0;
                        av_reg   <= '0;
                        bv_reg   <= '0;
                        busy_reg <= 1'b0;
                        done_reg <= 1'b1;
                    end else begin
                        step   <= step_next;
                        a_reg  <= a_next;
                        b_reg  <= b_next;
                        av_reg <= av_next;
                        bv_reg <= bv_next;
                    end
                end
                DONE: begin
                    state    <= LOAD;
                    wr_cnt   <= '0;
                    done_reg <= 1'b0;
                end
                default: state <= LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_matrix_skew_feeder.sv
module tb_matrix_skew_feeder;
    localparam int DW  = 32;
    localparam int DIM = 4;
    localparam int W   = DIM * DW;

    logic clk = 1'b0;
    logic reset;
    logic enable;

    matrix_skew_feeder_if #(.DATA_WIDTH(DW), .DIM(DIM)) bus ();

    matrix_skew_feeder #(.DATA_WIDTH(DW), .DIM(DIM)) dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [DIM-1:0] va;
        logic [DIM-1:0] vb;
    } vec_t;

    vec_t tbl [7];
    int   total = 0;
    int   bad   = 0;
    int   busy_cnt;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_step(input int s, input string tag);
        chk($sformatf("%s a_out s%0d", tag, s), bus.a_out, tbl[s].a);
        chk($sformatf("%s b_out s%0d", tag, s), bus.b_out, tbl[s].b);
        chk($sformatf("%s a_valid s%0d", tag, s), W'(bus.a_valid), W'(tbl[s].va));
        chk($sformatf("%s b_valid s%0d", tag, s), W'(bus.b_valid), W'(tbl[s].vb));
        chk($sformatf("%s busy s%0d", tag, s), W'(bus.busy), W'(1));
        chk($sformatf("%s loaded s%0d", tag, s), W'(bus.loaded), W'(0));
    endtask

    task automatic check_quiet(input string tag, input logic exp_ovf);
        chk({tag, " a_out"}, bus.a_out, '0);
        chk({tag, " b_out"}, bus.b_out, '0);
        chk({tag, " valids"}, W'({bus.a_valid, bus.b_valid}), '0);
        chk({tag, " busy"}, W'(bus.busy), '0);
        chk({tag, " loaded"}, W'(bus.loaded), '0);
        chk({tag, " overflow"}, W'(bus.overflow), W'(exp_ovf));
    endtask

    // Presents element k-1 while read_en for element k is asserted, so the
    // data lines up with the registered read strobe.
    task automatic load_elems(input int count);
        for (int k = 0; k <= count; k++) begin
            bus.read_en  = (k < count);
            bus.rom_data = (k >= 1) ? DW'(k)      : '0;
            bus.ram_data = (k >= 1) ? DW'(k + 16) : '0;
            tick();
        end
        bus.read_en = 1'b0;
    endtask

    // Feeds from FULL; optional enable stall after a step, optional reset
    // after a step (returns early in that case).
    task automatic run_feed(input string tag, input int stall_at, input int abort_at, input logic exp_ovf);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        busy_cnt = 0;
        for (int s = 0; s < 7; s++) begin
            check_step(s, tag);
            busy_cnt += int'(bus.busy);
            if (s == abort_at) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
                check_quiet({tag, " after reset"}, 1'b0);
                chk({tag, " done after reset"}, W'(bus.done), '0);
                return;
            end
            if (s == stall_at) begin
                enable = 1'b0;
                for (int h = 0; h < 3; h++) begin
                    tick();
                    check_step(s, {tag, " frozen"});
                end
                enable = 1'b1;
            end
            tick();
        end
        chk({tag, " done"}, W'(bus.done), W'(1));
        check_quiet({tag, " done cycle"}, exp_ovf);
        if (stall_at < 0) chk({tag, " busy cycles"}, W'(busy_cnt), W'(7));
        tick();
        chk({tag, " done drops"}, W'(bus.done), '0);
    endtask

    initial begin
        // Lane i = bits [i*32 +: 32]; A[k]=k+1, B[k]=k+17, row-major.
        tbl[0] = '{a: {32'd0, 32'd0,  32'd0,  32'd1},  b: {32'd0,  32'd0,  32'd0,  32'd17}, va: 4'b0001, vb: 4'b0001};
        tbl[1] = '{a: {32'd0, 32'd0,  32'd5,  32'd2},  b: {32'd0,  32'd0,  32'd18, 32'd21}, va: 4'b0011, vb: 4'b0011};
        tbl[2] = '{a: {32'd0, 32'd9,  32'd6,  32'd3},  b: {32'd0,  32'd19, 32'd22, 32'd25}, va: 4'b0111, vb: 4'b0111};
        tbl[3] = '{a: {32'd13, 32'd10, 32'd7, 32'd4},  b: {32'd20, 32'd23, 32'd26, 32'd29}, va: 4'b1111, vb: 4'b1111};
        tbl[4] = '{a: {32'd14, 32'd11, 32'd8, 32'd0},  b: {32'd24, 32'd27, 32'd30, 32'd0},  va: 4'b1110, vb: 4'b1110};
        tbl[5] = '{a: {32'd15, 32'd12, 32'd0, 32'd0},  b: {32'd28, 32'd31, 32'd0,  32'd0},  va: 4'b1100, vb: 4'b1100};
        tbl[6] = '{a: {32'd16, 32'd0,  32'd0, 32'd0},  b: {32'd32, 32'd0,  32'd0,  32'd0},  va: 4'b1000, vb: 4'b1000};

        reset        = 1'b1;
        enable       = 1'b1;
        bus.read_en  = 1'b0;
        bus.start    = 1'b0;
        bus.rom_data = '0;
        bus.ram_data = '0;
        tick();
        tick();
        reset = 1'b0;
        check_quiet("reset", 1'b0);
        chk("reset done", W'(bus.done), '0);

        // start while still in LOAD must be ignored
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("early start busy", W'(bus.busy), '0);

        load_elems(15);
        chk("15 loaded", W'(bus.loaded), '0);
        bus.read_en  = 1'b1;
        bus.rom_data = 32'd15;
        bus.ram_data = 32'd31;
        tick();
        bus.read_en  = 1'b0;
        bus.rom_data = 32'd16;
        bus.ram_data = 32'd32;
        tick();
        chk("16 loaded", W'(bus.loaded), W'(1));
        chk("load overflow", W'(bus.overflow), '0);

        // 17th capture in FULL: dropped, sticky overflow, bank[15] kept
        bus.rom_data = 32'hDEAD;
        bus.ram_data = 32'hBEEF;
        bus.read_en  = 1'b1;
        tick();
        bus.read_en  = 1'b0;
        tick();
        chk("extra overflow", W'(bus.overflow), W'(1));
        chk("extra loaded", W'(bus.loaded), W'(1));

        run_feed("feed1", -1, -1, 1'b1);

        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("ovf cleared", W'(bus.overflow), '0);
        load_elems(16);
        run_feed("stall", 2, -1, 1'b0);

        load_elems(16);
        run_feed("abort", -1, 4, 1'b0);

        load_elems(16);
        run_feed("reload", -1, -1, 1'b0);

`ifdef BANK_CLEAR_EN
        load_elems(8);
        dut.state = dut.FULL;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        tick();
        chk("clear a s3", bus.a_out, {32'd0, 32'd0, 32'd7, 32'd4});
        chk("clear b s3", bus.b_out, {32'd20, 32'd23, 32'd0, 32'd0});
        tick();
        tick();
        tick();
        chk("clear a s6", bus.a_out, '0);
        chk("clear b s6", bus.b_out, '0);
        chk("clear v s6", W'(bus.a_valid), W'(4'b1000));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
